audio_codec_i2c_target: RTL and testbench
=========================================

// Module: audio_codec_i2c_target
// PURPOSE
//  I2C target (responder) emulating the ADAU1761 control port: 7-bit device address, 16-bit
//  register address, auto-incrementing 8-bit data, write and read transfers. Sits on the same
//  sda/scl pair as the codec-init I2C master; serves as an on-fabric codec stand-in for
//  loopback/bring-up and exposes every register write to local logic. Runs on the 50 MHz init clock.
// PARAMETERS
//  DEV_ADDR   7'h3B    7-bit target address (write byte 0x76, read byte 0x77)
//  REG_BASE   16'h4000 first register address in the bank window
//  ADDR_BITS  8        bank depth = 2**ADDR_BITS bytes (window REG_BASE..REG_BASE+255)
//  FILT       4        clk cycles a sampled scl/sda level must hold before being accepted
// PORTS
//  clk       in     1  system clock, 50 MHz
//  rst       in     1  synchronous, active-low reset
//  scl       in     1  I2C clock (never driven; no clock stretching)
//  sda       inout  1  I2C data; driven only to 0, otherwise 'z'
//  wr_stb    out    1  one-cycle pulse per accepted in-window data byte
//  wr_addr   out    16 full register address of that byte (valid with wr_stb)
//  wr_data   out    8  byte written (valid with wr_stb)
//  rd_addr   in     ADDR_BITS  local read port address (bank offset)
//  rd_data   out    8  bank[rd_addr], registered, 1-cycle latency
//  busy      out    1  high from START to STOP, addressed or not
// BEHAVIOUR
//  Reset (rst=0 at clk edge): sda released, wr_stb=0, wr_addr=0, wr_data=0, rd_data=0, busy=0,
//   FSM=IDLE, pointer=0, bank cleared to 0x00. Reset mid-transfer releases sda in the same cycle.
//  Input path: 2-flop sync on scl/sda, then FILT-cycle stability filter; edges detected on
//   filtered signals. START = sda fall while scl=1; STOP = sda rise while scl=1.
//  Bits sampled on filtered scl rise, MSB first. Target changes sda only FILT+2 cycles after scl
//   fall (hold margin); ACK driven on the 8th-bit fall, released on the 9th-clock fall.
//  FSM: IDLE -> (START) DEV -> ACK_DEV -> REG_HI -> ACK_HI -> REG_LO -> ACK_LO -> WDATA <-> ACK_W.
//   DEV with R/W=1 -> ACK_DEV -> RDATA -> MACK -> RDATA (master ACK) or WAIT_STOP (master NACK).
//   DEV address mismatch -> no ACK, WAIT_STOP (ignore bus until STOP/START).
//  START (incl. repeated) in any state -> DEV, bit counter cleared; STOP in any state -> IDLE,
//   partial byte discarded, no strobe. pointer retained across transfers.
//  pointer = {REG_HI,REG_LO} latched at ACK_LO. Each WDATA byte: if pointer in window, bank
//   written and wr_stb pulses 1 cycle after the 8th bit rise; pointer += 1 (16-bit wrap FFFF->0000).
//   Out-of-window data bytes are ACKed but not stored, no wr_stb.
//  RDATA: byte = bank[pointer-REG_BASE] if in window else 0x00, loaded at ACK_DEV/MACK exit;
//   pointer += 1 after each byte; sda driven per bit (0 -> low, 1 -> release).
//  All address bytes and data bytes ACKed; only device-address mismatch NACKs.
//  Local write from I2C and rd_addr read of same offset in same cycle: rd_data returns old value.
// TESTING
//  1 Write 76 40 15 01 STOP -> 3 ACKs + data ACK; wr_stb once, wr_addr=4015, wr_data=01; rd_addr=15 -> 01.
//  2 Write 78 40 15 01 -> sda stays released on 9th clock; no wr_stb; busy 1 until STOP.
//  3 Write 76 40 02 00 7D 00 0C 20 01 -> 6 strobes, addrs 4002..4007, bank[02..07]=00 7D 00 0C 20 01.
//  4 Write 76 40 15, Sr, 77, read 1 byte, master NACK, STOP -> sda carries 01; pointer=4016.
//  5 Write 76 00 10 55 (out of window) -> all ACKed, no wr_stb, bank unchanged; read at 0010 -> 00.
//  6 rst=0 during data bit 4 of test 1 -> sda released next cycle, no strobe; next full write succeeds.

Source files
------------

// File: rtl/audio_codec_i2c_target.sv
// audio_codec_i2c_target
//   I2C target that stands in for the ADAU1761 control port: 7-bit device
//   address, 16-bit register address, auto-incrementing 8-bit data, write and
//   read transfers. Register writes landing in the bank window are stored
//   locally and announced on wr_stb.
// Ports
//   clk      system clock (50 MHz init clock)
//   rst      synchronous active-low reset
//   scl      I2C clock input (never driven, no stretching)
//   sda      I2C data, driven only low, otherwise released
//   wr_stb   one-cycle pulse per stored data byte, with wr_addr / wr_data
//   rd_addr  local read port offset; rd_data = bank[rd_addr], 1-cycle latency
//   busy     high from START to STOP
// States
//   IDLE      | bus free, waiting for START
//   DEV       | shifting in device address + R/W
//   ACK_DEV   | acknowledging device address
//   REG_HI    | shifting in register address high byte
//   ACK_HI    | acknowledging high byte
//   REG_LO    | shifting in register address low byte
//   ACK_LO    | acknowledging low byte (pointer already latched)
//   WDATA     | shifting in a write data byte
//   ACK_W     | acknowledging a write data byte
//   RDATA     | driving a read data byte
//   MACK      | master ACK/NACK slot after a read byte
//   WAIT_STOP | not addressed or read ended, ignoring bus until START/STOP
module audio_codec_i2c_target #(
  parameter logic [6:0]  DEV_ADDR  = 7'h3B,
  parameter logic [15:0] REG_BASE  = 16'h4000,
  parameter int          ADDR_BITS = 8,
  parameter int          FILT      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl,
  inout  logic                 sda,
  output logic                 wr_stb,
  output logic [15:0]          wr_addr,
  output logic [7:0]           wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [7:0]           rd_data,
  output logic                 busy
);
  localparam int FW    = $clog2(FILT + 1);
  localparam int HOLD  = FILT + 2;
  localparam int HW    = $clog2(HOLD + 1);
  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, REG_HI, ACK_HI, REG_LO, ACK_LO, WDATA, ACK_W, RDATA, MACK, WAIT_STOP
  } state_t;

  state_t state, state_n;

  logic [1:0]    scl_sync, sda_sync;
  logic          scl_f, sda_f, scl_q, sda_q;
  logic [FW-1:0] scl_cnt, sda_cnt;
  logic          scl_rise, scl_fall, start_c, stop_c;

  logic          sda_oe, pend_oe;
  logic [HW-1:0] hold_cnt;
  logic [3:0]    bit_cnt;
  logic [6:0]    shreg;
  logic [7:0]    tx, reg_hi;
  logic          rw, mack_ok;
  logic [15:0]   pointer;
  logic [7:0]    bank [DEPTH];

  logic          sched, sched_oe, load_tx;
  logic [7:0]    rx_byte, rd_byte;
  logic          last_bit, ninth, in_win;
  logic [15:0]   offs;

  // Reset also gates the driver so a mid-transfer reset frees the bus at once.
  assign sda = (sda_oe && rst) ? 1'b0 : 1'bz;

  // Sync + stability filter: a new level must persist FILT cycles to be taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      scl_cnt  <= FW'(FILT - 1);
      sda_cnt  <= FW'(FILT - 1);
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_q    <= scl_f;
      sda_q    <= sda_f;
      if (scl_sync[1] == scl_f) scl_cnt <= FW'(FILT - 1);
      else if (scl_cnt == '0) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= FW'(FILT - 1);
      end else scl_cnt <= scl_cnt - 1'b1;
      if (sda_sync[1] == sda_f) sda_cnt <= FW'(FILT - 1);
      else if (sda_cnt == '0) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= FW'(FILT - 1);
      end else sda_cnt <= sda_cnt - 1'b1;
    end
  end

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

  assign rx_byte  = {shreg, sda_f};
  assign last_bit = (bit_cnt == 4'd7);
  assign ninth    = bit_cnt[3];  // set by the 9th-clock rise inside ACK/MACK slots
  assign offs     = pointer - REG_BASE;
  assign in_win   = (offs[15:ADDR_BITS] == '0);
  assign rd_byte  = in_win ? bank[offs[ADDR_BITS-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // sched requests an sda change, applied HOLD cycles later for hold margin.
  always_comb begin
    state_n  = state;
    sched    = 1'b0;
    sched_oe = 1'b0;
    load_tx  = 1'b0;
    if (start_c) state_n = DEV;
    else if (stop_c) state_n = IDLE;
    else begin
      case (state)
        DEV:    if (scl_rise && last_bit) state_n = (rx_byte[7:1] == DEV_ADDR) ? ACK_DEV : WAIT_STOP;
        REG_HI: if (scl_rise && last_bit) state_n = ACK_HI;
        REG_LO: if (scl_rise && last_bit) state_n = ACK_LO;
        WDATA:  if (scl_rise && last_bit) state_n = ACK_W;
        RDATA: begin
          if (scl_rise && last_bit) state_n = MACK;
          if (scl_fall) begin
            sched    = 1'b1;
            sched_oe = ~tx[6];
          end
        end
        ACK_DEV, ACK_HI, ACK_LO, ACK_W: begin
          if (scl_fall) begin
            sched = 1'b1;
            if (!ninth) sched_oe = 1'b1;
            else if (state == ACK_DEV) begin
              state_n = rw ? RDATA : REG_HI;
              if (rw) begin
                load_tx  = 1'b1;
                sched_oe = ~rd_byte[7];
              end
            end else if (state == ACK_HI) state_n = REG_LO;
            else state_n = WDATA;
          end
        end
        MACK: begin
          if (scl_fall) begin
            sched = 1'b1;
            if (ninth) begin
              if (mack_ok) begin
                state_n  = RDATA;
                load_tx  = 1'b1;
                sched_oe = ~rd_byte[7];
              end else state_n = WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sda_oe   <= 1'b0;
      pend_oe  <= 1'b0;
      hold_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= '0;
      reg_hi   <= '0;
      rw       <= 1'b0;
      mack_ok  <= 1'b0;
      pointer  <= '0;
      busy     <= 1'b0;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_data  <= '0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= 8'h00;
    end else begin
      wr_stb  <= 1'b0;
      rd_data <= bank[rd_addr];
      if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
        if (hold_cnt == HW'(1)) sda_oe <= pend_oe;
      end
      if (sched) begin
        pend_oe  <= sched_oe;
        hold_cnt <= HW'(HOLD);
      end
      if (start_c || stop_c) begin
        busy     <= start_c;
        bit_cnt  <= '0;
        sda_oe   <= 1'b0;
        hold_cnt <= '0;
      end else if (scl_rise) begin
        if (state inside {DEV, REG_HI, REG_LO, WDATA, RDATA}) begin
          shreg   <= rx_byte[6:0];
          bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
        end else if (state inside {ACK_DEV, ACK_HI, ACK_LO, ACK_W, MACK}) begin
          bit_cnt <= 4'd8;
        end
        if (state == MACK) mack_ok <= ~sda_f;
        if (last_bit) begin
          case (state)
            DEV:    rw <= rx_byte[0];
            REG_HI: reg_hi <= rx_byte;
            REG_LO: pointer <= {reg_hi, rx_byte};
            WDATA: begin
              if (in_win) begin
                bank[offs[ADDR_BITS-1:0]] <= rx_byte;
                wr_stb  <= 1'b1;
                wr_addr <= pointer;
                wr_data <= rx_byte;
              end
              pointer <= pointer + 16'd1;
            end
            default: ;
          endcase
        end
      end else if (scl_fall) begin
        if (ninth) bit_cnt <= '0;
        if (state == RDATA) tx <= {tx[6:0], 1'b0};
        if (load_tx) begin
          tx      <= rd_byte;
          pointer <= pointer + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_codec_i2c_target.sv
// tb_audio_codec_i2c_target
//   Bit-banged I2C master driving audio_codec_i2c_target, with a transfer-level
//   model of the register bank, pointer and expected write strobes.
module tb_audio_codec_i2c_target;
  localparam int Q = 25;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_low = 1'b0;
  logic [7:0]  rd_addr = 8'h00;
  wire         sda_bus;
  logic        wr_stb;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data, rd_data;
  logic        busy;

  pullup (sda_bus);
  assign sda_bus = sda_low ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  audio_codec_i2c_target dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda(sda_bus),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int n_stb = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transfer-level model
  typedef struct packed {logic [15:0] a; logic [7:0] d; logic [7:0] old;} wr_t;
  wr_t         exp_q[$];
  logic [7:0]  m_bank [256];
  logic [15:0] m_ptr;
  logic [7:0]  m_hi;
  int          m_idx;
  logic        m_addr_ok;

  function automatic void mdl_reset();
    for (int i = 0; i < 256; i++) m_bank[i] = 8'h00;
    m_ptr = 16'h0000;
    m_idx = 0;
    m_addr_ok = 1'b0;
    exp_q.delete();
  endfunction

  function automatic logic mdl_wbyte(input logic [7:0] b);
    logic [15:0] off;
    if (m_idx == 0) m_addr_ok = (b[7:1] == 7'h3B);
    else if (m_addr_ok) begin
      if (m_idx == 1) m_hi = b;
      else if (m_idx == 2) m_ptr = {m_hi, b};
      else begin
        off = m_ptr - 16'h4000;
        if (off < 16'd256) begin
          exp_q.push_back(wr_t'{a: m_ptr, d: b, old: m_bank[off[7:0]]});
          m_bank[off[7:0]] = b;
        end
        m_ptr = m_ptr + 16'd1;
      end
    end
    m_idx++;
    return m_addr_ok;
  endfunction

  function automatic logic [7:0] mdl_rbyte();
    logic [15:0] off;
    logic [7:0]  r;
    off = m_ptr - 16'h4000;
    r = (off < 16'd256) ? m_bank[off[7:0]] : 8'h00;
    m_ptr = m_ptr + 16'd1;
    return r;
  endfunction

  // Bus primitives
  task automatic wc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_low = 1'b1; wc(Q);
    scl_m = 1'b0;   wc(Q);
    m_idx = 0;
  endtask

  task automatic bus_rstart();
    sda_low = 1'b0; wc(Q);
    scl_m = 1'b1;   wc(Q);
    sda_low = 1'b1; wc(Q);
    scl_m = 1'b0;   wc(Q);
    m_idx = 0;
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; wc(Q);
    scl_m = 1'b1;   wc(Q);
    sda_low = 1'b0; wc(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b;  wc(Q);
    scl_m = 1'b1;  wc(2 * Q);
    scl_m = 1'b0;  wc(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_low = 1'b0; wc(Q);
    scl_m = 1'b1;   wc(Q);
    b = sda_bus;    wc(Q);
    scl_m = 1'b0;   wc(Q);
  endtask

  task automatic wbyte(input logic [7:0] b, input string nm);
    logic exp_ack, a, got_ack;
    exp_ack = mdl_wbyte(b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
    got_ack = ~a;
    chk(nm, {31'b0, got_ack}, {31'b0, exp_ack});
  endtask

  task automatic rbyte(input logic nack, input string nm, output logic [7:0] got);
    logic [7:0] exp;
    logic       b;
    exp = mdl_rbyte();
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      got[i] = b;
    end
    send_bit(nack);
    chk(nm, got, exp);
  endtask

  // Every strobe must match the next model write, in order.
  initial begin : cmp
    wr_t        e;
    logic       nxt;
    logic [7:0] nxt_val;
    nxt = 1'b0;
    nxt_val = 8'h00;
    forever begin
      @(negedge clk);
      if (nxt) begin
        chk("rd_after_wr", rd_data, nxt_val);
        nxt = 1'b0;
      end
      if (rst && wr_stb) begin
        n_stb++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wr_stb actual=%0h/%0h required=none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", wr_data, e.d);
          if ((wr_addr - 16'h4000) == {8'h00, rd_addr}) begin
            chk("rd_same_cycle_old", rd_data, e.old);
            nxt = 1'b1;
            nxt_val = e.d;
          end
        end
      end
    end
  end

  initial begin : main
    logic [7:0] got;
    logic [7:0] v;
    logic [7:0] t3_exp [6];
    t3_exp = '{8'h00, 8'h7D, 8'h00, 8'h0C, 8'h20, 8'h01};
    mdl_reset();

    wc(5);
    chk("rst_busy", busy, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_sda", sda_bus, 1);
    rst = 1'b1;
    wc(20);

    // 1: single write in window
    n_stb = 0;
    bus_start();
    wbyte(8'h76, "t1_dev_ack");
    wbyte(8'h40, "t1_hi_ack");
    wbyte(8'h15, "t1_lo_ack");
    wbyte(8'h01, "t1_data_ack");
    chk("t1_busy_mid", busy, 1);
    bus_stop();
    wc(20);
    chk("t1_busy_after", busy, 0);
    chk("t1_stb_count", n_stb, 1);
    rd_addr = 8'h15;
    wc(3);
    chk("t1_rd15", rd_data, 8'h01);

    // 2: wrong device address
    n_stb = 0;
    bus_start();
    wbyte(8'h78, "t2_dev_nack");
    wbyte(8'h40, "t2_b1_nack");
    wbyte(8'h15, "t2_b2_nack");
    wbyte(8'h01, "t2_b3_nack");
    chk("t2_busy_mid", busy, 1);
    bus_stop();
    wc(20);
    chk("t2_busy_after", busy, 0);
    chk("t2_stb_count", n_stb, 0);

    // 3: burst with auto-increment, local read parked on offset 05
    n_stb = 0;
    rd_addr = 8'h05;
    bus_start();
    wbyte(8'h76, "t3_dev_ack");
    wbyte(8'h40, "t3_hi_ack");
    wbyte(8'h02, "t3_lo_ack");
    wbyte(8'h00, "t3_d0_ack");
    wbyte(8'h7D, "t3_d1_ack");
    wbyte(8'h00, "t3_d2_ack");
    wbyte(8'h0C, "t3_d3_ack");
    wbyte(8'h20, "t3_d4_ack");
    wbyte(8'h01, "t3_d5_ack");
    bus_stop();
    wc(20);
    chk("t3_stb_count", n_stb, 6);
    chk("t3_queue_drained", exp_q.size(), 0);
    for (int i = 0; i < 6; i++) begin
      rd_addr = 8'(2 + i);
      wc(3);
      chk("t3_bank", rd_data, t3_exp[i]);
    end

    // 4: set pointer, repeated start, read one byte, NACK
    bus_start();
    wbyte(8'h76, "t4_dev_ack");
    wbyte(8'h40, "t4_hi_ack");
    wbyte(8'h15, "t4_lo_ack");
    bus_rstart();
    wbyte(8'h77, "t4_rdev_ack");
    rbyte(1'b1, "t4_read_mdl", got);
    chk("t4_read_lit", got, 8'h01);
    bus_stop();
    wc(20);
    // current-address read: pointer must now sit at 4016 (bank[16] = 00)
    bus_start();
    wbyte(8'h77, "t4b_rdev_ack");
    rbyte(1'b1, "t4b_read_mdl", got);
    chk("t4b_read_lit", got, 8'h00);
    bus_stop();
    wc(20);

    // 5: out-of-window write and read
    n_stb = 0;
    bus_start();
    wbyte(8'h76, "t5_dev_ack");
    wbyte(8'h00, "t5_hi_ack");
    wbyte(8'h10, "t5_lo_ack");
    wbyte(8'h55, "t5_data_ack");
    bus_stop();
    wc(20);
    chk("t5_stb_count", n_stb, 0);
    rd_addr = 8'h10;
    wc(3);
    chk("t5_bank10", rd_data, 8'h00);
    bus_start();
    wbyte(8'h76, "t5r_dev_ack");
    wbyte(8'h00, "t5r_hi_ack");
    wbyte(8'h10, "t5r_lo_ack");
    bus_rstart();
    wbyte(8'h77, "t5r_rdev_ack");
    rbyte(1'b1, "t5r_read_mdl", got);
    chk("t5r_read_lit", got, 8'h00);
    bus_stop();
    wc(20);

    // reset while the target is driving ACK low
    v = 8'h76;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    sda_low = 1'b0; wc(Q);
    scl_m = 1'b1;   wc(Q / 2);
    chk("ack_driven_low", sda_bus, 0);
    rst = 1'b0;
    wc(1);
    chk("rst_releases_sda", sda_bus, 1);
    wc(3);
    rst = 1'b1;
    mdl_reset();
    wc(Q);
    scl_m = 1'b0; wc(Q);
    bus_stop();
    wc(20);
    chk("ackrst_busy", busy, 0);

    // 6: reset during data bit 4, then a clean write
    n_stb = 0;
    bus_start();
    wbyte(8'h76, "t6_dev_ack");
    wbyte(8'h40, "t6_hi_ack");
    wbyte(8'h15, "t6_lo_ack");
    v = 8'h01;
    send_bit(v[7]);
    send_bit(v[6]);
    send_bit(v[5]);
    sda_low = ~v[4]; wc(Q);
    scl_m = 1'b1;    wc(Q);
    rst = 1'b0;
    wc(3);
    rst = 1'b1;
    mdl_reset();
    wc(Q);
    scl_m = 1'b0; wc(Q);
    bus_stop();
    wc(20);
    chk("t6_abort_stb", n_stb, 0);
    chk("t6_abort_busy", busy, 0);
    rd_addr = 8'h15;
    wc(3);
    chk("t6_bank_cleared", rd_data, 8'h00);
    bus_start();
    wbyte(8'h76, "t6w_dev_ack");
    wbyte(8'h40, "t6w_hi_ack");
    wbyte(8'h15, "t6w_lo_ack");
    wbyte(8'h01, "t6w_data_ack");
    bus_stop();
    wc(20);
    chk("t6w_stb_count", n_stb, 1);
    chk("t6w_rd15", rd_data, 8'h01);

    wc(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
